ascii2ps2_tx: RTL and testbench



---
 rtl/ps2_pkg.sv | 33 +++
 rtl/ascii2scan.sv | 30 +++
 rtl/ascii2ps2_tx.sv | 162 ++++++++++++++++
 tb/tb_ascii2ps2_tx.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: set-2 scan codes, break prefix, FSM states,
// frame length and the 11-bit frame builder.
package ps2_pkg;

  localparam logic [7:0] SC_0     = 8'h45;
  localparam logic [7:0] SC_1     = 8'h16;
  localparam logic [7:0] SC_2     = 8'h1E;
  localparam logic [7:0] SC_3     = 8'h26;
  localparam logic [7:0] SC_4     = 8'h25;
  localparam logic [7:0] SC_5     = 8'h2E;
  localparam logic [7:0] SC_6     = 8'h36;
  localparam logic [7:0] SC_7     = 8'h3D;
  localparam logic [7:0] SC_8     = 8'h3E;
  localparam logic [7:0] SC_9     = 8'h46;
  localparam logic [7:0] SC_ENTER = 8'h5A;

  localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;

  localparam int unsigned FRAME_BITS = 11;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    GAP
  } ps2_state_e;

  // {stop, odd parity, data[7:0], start}; bit 0 goes out first.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] data);
    return {1'b1, ~^data, data, 1'b0};
  endfunction

endpackage

// File: rtl/ascii2scan.sv
// Combinational ASCII to PS/2 set-2 make-code lookup ('0'..'9' and CR).
module ascii2scan
  import ps2_pkg::*;
(
  input  logic [7:0] ascii,
  output logic [7:0] scan,
  output logic       hit
);

  // Table lookup; anything not listed reports hit=0.
  always_comb begin
    scan = '0;
    hit  = 1'b1;
    case (ascii)
      8'h30:   scan = SC_0;
      8'h31:   scan = SC_1;
      8'h32:   scan = SC_2;
      8'h33:   scan = SC_3;
      8'h34:   scan = SC_4;
      8'h35:   scan = SC_5;
      8'h36:   scan = SC_6;
      8'h37:   scan = SC_7;
      8'h38:   scan = SC_8;
      8'h39:   scan = SC_9;
      8'h0D:   scan = SC_ENTER;
      default: hit  = 1'b0;
    endcase
  end

endmodule

// File: rtl/ascii2ps2_tx.sv
// Device-side PS/2 keystroke generator: ASCII in (valid/ready), PS/2
// device-to-host frames out on ps2c/ps2d.
// Optional macro PS2_BREAK_CODE_EN: send code, F0, code per key instead of
// the make code alone.
module ascii2ps2_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 2500,
  parameter int unsigned GAP_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] ascii_in,
  input  logic       ascii_valid,
  output logic       ascii_ready,
  output logic       ps2c,
  output logic       ps2d,
  output logic       busy,
  output logic       unmapped
);

  localparam int unsigned HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
  localparam logic [3:0]    BIT_LAST  = 4'(FRAME_BITS - 1);

  ps2_state_e            state_q, state_d;
  logic [7:0]            ascii_q, ascii_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic [3:0]            bit_q, bit_d;
  logic [HW-1:0]         half_q, half_d;
  logic                  phase_q, phase_d;
  logic [GW-1:0]         gap_q, gap_d;

  logic [7:0] scan;
  logic       hit;
  logic [7:0] tx_byte;
  logic       seq_last;

  ascii2scan u_ascii2scan (
    .ascii (ascii_q),
    .scan  (scan),
    .hit   (hit)
  );

`ifdef PS2_BREAK_CODE_EN
  logic [1:0] seq_q;

  // Byte index within the key sequence; advances at the end of each gap.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      seq_q <= '0;
    end else if (state_q == IDLE) begin
      seq_q <= '0;
    end else if (state_q == GAP && gap_q == GAP_LAST && seq_q != 2'd2) begin
      seq_q <= seq_q + 2'd1;
    end
  end

  assign seq_last = (seq_q == 2'd2);
  assign tx_byte  = (seq_q == 2'd1) ? PS2_BREAK_PREFIX : scan;
`else
  assign seq_last = 1'b1;
  assign tx_byte  = scan;
`endif

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ascii_q <= '0;
      frame_q <= '1;
      bit_q   <= '0;
      half_q  <= '0;
      phase_q <= 1'b0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      ascii_q <= ascii_d;
      frame_q <= frame_d;
      bit_q   <= bit_d;
      half_q  <= half_d;
      phase_q <= phase_d;
      gap_q   <= gap_d;
    end
  end

  // Next-state logic and line drive. The LOAD cycle already shows the start
  // bit, so it counts as the first cycle of the start bit's high phase and
  // the half-period counter is preloaded past it.
  always_comb begin
    state_d     = state_q;
    ascii_d     = ascii_q;
    frame_d     = frame_q;
    bit_d       = bit_q;
    half_d      = half_q;
    phase_d     = phase_q;
    gap_d       = gap_q;
    ascii_ready = 1'b0;
    busy        = 1'b1;
    unmapped    = 1'b0;
    ps2c        = 1'b1;
    ps2d        = 1'b1;
    case (state_q)
      IDLE: begin
        ascii_ready = 1'b1;
        busy        = 1'b0;
        if (ascii_valid) begin
          ascii_d = ascii_in;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (!hit) begin
          unmapped = 1'b1;
          state_d  = IDLE;
        end else begin
          ps2d    = 1'b0;
          frame_d = build_frame(tx_byte);
          bit_d   = '0;
          gap_d   = '0;
          if (CLK_DIV == 1) begin
            phase_d = 1'b1;
            half_d  = '0;
          end else begin
            phase_d = 1'b0;
            half_d  = HW'(1);
          end
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        ps2c = ~phase_q;
        ps2d = frame_q[bit_q];
        if (half_q == HALF_LAST) begin
          half_d  = '0;
          phase_d = ~phase_q;
          if (phase_q) begin
            if (bit_q == BIT_LAST) begin
              gap_d   = '0;
              state_d = GAP;
            end else begin
              bit_d = bit_q + 4'd1;
            end
          end
        end else begin
          half_d = half_q + HW'(1);
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = seq_last ? IDLE : LOAD;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ascii2ps2_tx.sv
// Bench for ascii2ps2_tx with a short PS/2 bit period and gap.
module tb_ascii2ps2_tx;

  localparam int CD = 4;
  localparam int GP = 10;
`ifdef PS2_BREAK_CODE_EN
  localparam int NF  = 3;
  localparam bit BRK = 1'b1;
`else
  localparam int NF  = 1;
  localparam bit BRK = 1'b0;
`endif
  localparam int KEY_CYC = NF * (22 * CD + GP);

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] ascii_in;
  logic       ascii_valid;
  logic       ascii_ready;
  logic       ps2c;
  logic       ps2d;
  logic       busy;
  logic       unmapped;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  ascii2ps2_tx #(
    .CLK_DIV    (CD),
    .GAP_CYCLES (GP)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ascii_in    (ascii_in),
    .ascii_valid (ascii_valid),
    .ascii_ready (ascii_ready),
    .ps2c        (ps2c),
    .ps2d        (ps2d),
    .busy        (busy),
    .unmapped    (unmapped)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int frame_ones(input logic [7:0] b);
    int n;
    n = $countones(b);
    if (n % 2 == 0) n = n + 1;  // parity bit set to make the count odd
    return n + 1;               // stop bit
  endfunction

  function automatic int key_hi(input logic [7:0] code);
    if (BRK) return 2 * (CD * frame_ones(code) + GP) + CD * frame_ones(8'hF0) + GP;
    return CD * frame_ones(code) + GP;
  endfunction

  task automatic push_key(input logic [7:0] code);
    exp_q.push_back(code);
    if (BRK) begin
      exp_q.push_back(8'hF0);
      exp_q.push_back(code);
    end
  endtask

  // Frame receiver: samples ps2d on each falling ps2c.
  logic        mon_prev_c;
  logic [10:0] mon_bits;
  int          mon_nb;
  logic [7:0]  mon_exp;

  initial begin
    mon_prev_c = 1'b1;
    mon_nb     = 0;
    mon_bits   = '0;
    forever begin
      @(negedge clk);
      if (reset_n !== 1'b1) begin
        mon_nb = 0;
      end else if (mon_prev_c === 1'b1 && ps2c === 1'b0) begin
        mon_bits[mon_nb] = ps2d;
        mon_nb++;
        if (mon_nb == 11) begin
          mon_nb = 0;
          check("frame_start", 32'(mon_bits[0]), 32'd0);
          check("frame_stop", 32'(mon_bits[10]), 32'd1);
          check("frame_parity", 32'(^mon_bits[9:1]), 32'd1);
          check("frame_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            check("frame_data", 32'(mon_bits[8:1]), 32'(mon_exp));
          end
        end
      end
      mon_prev_c = ps2c;
    end
  end

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (ascii_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready_wait"}, 32'(ascii_ready), 32'd1);
  endtask

  // Handshake one character; returns at the negedge of the cycle after it.
  task automatic send(input logic [7:0] c, input string tag);
    wait_ready(tag);
    ascii_in    = c;
    ascii_valid = 1'b1;
    @(posedge clk);
    #1;
    ascii_valid = 1'b0;
    ascii_in    = 8'hFF;
    @(negedge clk);
  endtask

  // Called at the negedge of the LOAD cycle; follows the key until idle.
  task automatic key_run(input logic [7:0] code, input string tag);
    int n, hi, cl;
    check({tag, "_start_bit"}, 32'(ps2d), 32'd0);
    check({tag, "_start_clk"}, 32'(ps2c), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_ready_low"}, 32'(ascii_ready), 32'd0);
    n = 0; hi = 0; cl = 0;
    while (busy === 1'b1 && n < KEY_CYC + 100) begin
      n++;
      if (ps2c === 1'b1 && ps2d === 1'b1) hi++;
      if (ps2c === 1'b0) cl++;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, 32'(n), 32'(KEY_CYC));
    check({tag, "_high_cycles"}, 32'(hi), 32'(key_hi(code)));
    check({tag, "_clk_low_cycles"}, 32'(cl), 32'(NF * 11 * CD));
    check({tag, "_idle_lines"}, {30'd0, ps2c, ps2d}, 32'd3);
    check({tag, "_idle_ready"}, 32'(ascii_ready), 32'd1);
  endtask

  initial begin
    int n;
    reset_n     = 1'b0;
    ascii_in    = 8'h00;
    ascii_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ps2c", 32'(ps2c), 32'd1);
    check("rst_ps2d", 32'(ps2d), 32'd1);
    check("rst_ready", 32'(ascii_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_unmapped", 32'(unmapped), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // '0'
    push_key(8'h45);
    send(8'h30, "k0");
    key_run(8'h45, "k0");

    // '5'
    push_key(8'h2E);
    send(8'h35, "k5");
    key_run(8'h2E, "k5");

    // carriage return
    push_key(8'h5A);
    send(8'h0D, "kcr");
    key_run(8'h5A, "kcr");

    // 'A' is unmapped
    send(8'h41, "kA");
    check("kA_pulse", 32'(unmapped), 32'd1);
    check("kA_ready_low", 32'(ascii_ready), 32'd0);
    check("kA_lines", {30'd0, ps2c, ps2d}, 32'd3);
    @(negedge clk);
    check("kA_pulse_end", 32'(unmapped), 32'd0);
    check("kA_ready_back", 32'(ascii_ready), 32'd1);
    check("kA_busy", 32'(busy), 32'd0);
    check("kA_lines2", {30'd0, ps2c, ps2d}, 32'd3);

    // '1' then '2' with valid held high
    wait_ready("k12");
    push_key(8'h16);
    push_key(8'h1E);
    ascii_in    = 8'h31;
    ascii_valid = 1'b1;
    @(posedge clk);
    #1;
    ascii_in = 8'h32;
    @(negedge clk);
    check("k12_ready_low", 32'(ascii_ready), 32'd0);
    check("k12_busy", 32'(busy), 32'd1);
    n = 0;
    while (ascii_ready !== 1'b1 && n < KEY_CYC + 100) begin
      @(negedge clk);
      n++;
    end
    check("k12_first_cycles", 32'(n), 32'(KEY_CYC));
    @(posedge clk);
    #1;
    ascii_valid = 1'b0;
    ascii_in    = 8'hFF;
    @(negedge clk);
    key_run(8'h1E, "k2");

    // reset during data bit 4 of '3' (0x26), then a clean '7'
    send(8'h33, "kab");
    repeat (11 * CD + 1) @(negedge clk);
    check("kab_clk_low", 32'(ps2c), 32'd0);
    check("kab_data_bit4", 32'(ps2d), 32'd0);
    reset_n = 1'b0;
    @(negedge clk);
    check("kab_lines", {30'd0, ps2c, ps2d}, 32'd3);
    check("kab_busy", 32'(busy), 32'd0);
    check("kab_ready", 32'(ascii_ready), 32'd1);
    reset_n = 1'b1;
    @(negedge clk);
    push_key(8'h3D);
    send(8'h37, "k7");
    key_run(8'h3D, "k7");

    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
